braun_mac_acc: RTL and testbench



---
 rtl/braun_mac_pkg.sv | 14 +
 rtl/braun_mac_add.sv | 27 ++
 rtl/braun_mac_acc.sv | 88 ++++++++
 tb/tb_braun_mac_acc.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/braun_mac_pkg.sv
// Shared state encoding and default widths for the Braun multiplier accumulate stage.
package braun_mac_pkg;

  localparam int DEF_PROD_W = 16;
  localparam int DEF_ACC_W  = 24;
  localparam int DEF_CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/braun_mac_add.sv
// Accumulator adder: ACC_W + zero-extended PROD_W with carry-out.
// Clamps to all-ones on carry when BRAUN_MAC_SATURATE_EN is defined.
module braun_mac_add
  import braun_mac_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              carry_o
);

  logic [ACC_W:0] total;

  assign total   = {1'b0, acc_i} + (ACC_W+1)'(prod_i);
  assign carry_o = total[ACC_W];

`ifdef BRAUN_MAC_SATURATE_EN
  // Once clamped, every later add carries again, so the value sticks at max.
  assign sum_o = total[ACC_W] ? {ACC_W{1'b1}} : total[ACC_W-1:0];
`else
  assign sum_o = total[ACC_W-1:0];
`endif

endmodule

// File: rtl/braun_mac_acc.sv
// Burst accumulator for the Braun multiplier product stream (IDLE/ACC/HOLD).
// Optional clamp-on-overflow: define BRAUN_MAC_SATURATE_EN.
module braun_mac_acc
  import braun_mac_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod,
  output logic              prod_ready,
  output logic              res_valid,
  output logic [ACC_W-1:0]  res,
  input  logic              res_ready,
  output logic              busy,
  output logic              ovf
);

  state_e           state_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] cnt_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic             ovf_q;
  logic             carry_d;

  braun_mac_add #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .acc_i   (acc_q),
    .prod_i  (prod),
    .sum_o   (acc_d),
    .carry_o (carry_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            len_q   <= len;
            cnt_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= (len == '0) ? ST_HOLD : ST_ACC;
          end
        end
        ST_ACC: begin
          // prod_ready is high throughout ACC, so prod_valid alone marks a beat.
          if (prod_valid) begin
            acc_q <= acc_d;
            ovf_q <= ovf_q | carry_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == len_q - CNT_W'(1)) begin
              state_q <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (res_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // All handshake outputs decode straight from registers: no input-to-output paths.
  assign prod_ready = (state_q == ST_ACC);
  assign res_valid  = (state_q == ST_HOLD);
  assign busy       = (state_q != ST_IDLE);
  assign res        = acc_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_braun_mac_acc.sv
// Self-checking bench for braun_mac_acc (ACC_W=18): directed table, reset abort, random bursts.
module tb_braun_mac_acc;

  localparam int PW = 16;
  localparam int AW = 18;
  localparam int CW = 4;
  localparam longint MODV = 64'd1 << AW;
`ifdef BRAUN_MAC_SATURATE_EN
  localparam longint OVF_RES = 262143;
`else
  localparam longint OVF_RES = 188943;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] len = '0;
  logic          prod_valid = 1'b0;
  logic [PW-1:0] prod = '0;
  logic          prod_ready;
  logic          res_valid;
  logic [AW-1:0] res;
  logic          res_ready = 1'b0;
  logic          busy;
  logic          ovf;

  int n_total = 0;
  int n_bad   = 0;
  int bq[16];

  braun_mac_acc #(.PROD_W(PW), .ACC_W(AW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .prod_valid (prod_valid),
    .prod       (prod),
    .prod_ready (prod_ready),
    .res_valid  (res_valid),
    .res        (res),
    .res_ready  (res_ready),
    .busy       (busy),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    string  name;
    int     blen;
    int     p0;
    int     p1;
    int     p2;
    int     fill;
    int     gap;
    int     rdy_delay;
    bit     ign;
    longint exp_res;
    bit     exp_ovf;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain sum of the burst, then wrap or clamp at 2^AW.
  function automatic void model(input int blen, output longint r, output bit o);
    longint s = 0;
    for (int i = 0; i < blen; i++) s += longint'(bq[i]);
    o = (s >= MODV);
`ifdef BRAUN_MAC_SATURATE_EN
    r = o ? MODV - 1 : s;
`else
    r = s % MODV;
`endif
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_burst(input string name, input int blen, input int gap, input int rdy_delay,
                           input bit ign, input longint exp_res, input bit exp_ovf);
    start = 1'b1;
    len   = CW'(blen);
    @(negedge clk);
    start = 1'b0;
    len   = '0;
    check({name, " ovf_cleared"}, ovf, 0);
    if (blen == 0) check({name, " zero_len_ready"}, prod_ready, 0);
    for (int i = 0; i < blen; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          prod_valid = 1'b0;
          @(negedge clk);
        end
      end
      check({name, " prod_ready"}, prod_ready, 1);
      prod_valid = 1'b1;
      prod       = PW'(bq[i]);
      if (ign && i == 1) begin
        start = 1'b1;
        len   = 4'd5;
      end
      @(negedge clk);
      start = 1'b0;
      len   = '0;
    end
    prod_valid = 1'b0;
    prod       = '0;
    check({name, " res_valid"}, res_valid, 1);
    check({name, " ready_low"}, prod_ready, 0);
    check({name, " busy"}, busy, 1);
    check({name, " res"}, res, exp_res);
    check({name, " ovf"}, ovf, exp_ovf);
    for (int d = 0; d < rdy_delay; d++) begin
      if (ign && d == 0) begin
        start = 1'b1;
        len   = 4'd5;
      end
      @(negedge clk);
      start = 1'b0;
      len   = '0;
      check({name, " hold_valid"}, res_valid, 1);
      check({name, " hold_res"}, res, exp_res);
      check({name, " hold_ready"}, prod_ready, 0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({name, " valid_drop"}, res_valid, 0);
    check({name, " busy_drop"}, busy, 0);
    check({name, " res_idle"}, res, exp_res);
    if (ign) begin
      @(negedge clk);
      check({name, " no_extra_burst"}, busy, 0);
    end
  endtask

  initial begin
    longint er;
    bit     eo;
    int     rl;

    tbl[0] = '{"basic",    3, 195,   65025, 200,   0,     0, 0, 1'b0, 65420,   1'b0};
    tbl[1] = '{"bubbles",  3, 195,   65025, 200,   0,     2, 5, 1'b0, 65420,   1'b0};
    tbl[2] = '{"zero_len", 0, 0,     0,     0,     0,     0, 2, 1'b0, 0,       1'b0};
    tbl[3] = '{"overflow", 15, 65025, 65025, 65025, 65025, 0, 1, 1'b0, OVF_RES, 1'b1};
    tbl[4] = '{"ign_start", 3, 195,  65025, 200,   0,     1, 2, 1'b1, 65420,   1'b0};

    #12;
    check("rst prod_ready", prod_ready, 0);
    check("rst res_valid", res_valid, 0);
    check("rst res", res, 0);
    check("rst busy", busy, 0);
    check("rst ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 16; i++) bq[i] = (i == 0) ? tbl[t].p0 : (i == 1) ? tbl[t].p1 :
                                            (i == 2) ? tbl[t].p2 : tbl[t].fill;
      run_burst(tbl[t].name, tbl[t].blen, tbl[t].gap, tbl[t].rdy_delay, tbl[t].ign,
                tbl[t].exp_res, tbl[t].exp_ovf);
    end

    // Asynchronous reset after two of three beats.
    bq[0] = 195; bq[1] = 65025;
    start = 1'b1; len = 4'd3;
    @(negedge clk);
    start = 1'b0; len = '0;
    for (int i = 0; i < 2; i++) begin
      prod_valid = 1'b1; prod = PW'(bq[i]);
      @(negedge clk);
    end
    prod_valid = 1'b0; prod = '0;
    check("midrst partial", res, 65220);
    #2 rst_n = 1'b0;
    #1;
    check("midrst prod_ready", prod_ready, 0);
    check("midrst res_valid", res_valid, 0);
    check("midrst res", res, 0);
    check("midrst busy", busy, 0);
    check("midrst ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bq[0] = 128;
    run_burst("after_rst", 1, 0, 0, 1'b0, 128, 1'b0);

    for (int r = 0; r < 25; r++) begin
      rl = int'($urandom_range(0, 15));
      for (int i = 0; i < 16; i++) bq[i] = int'($urandom_range(0, 255) * $urandom_range(0, 255));
      model(rl, er, eo);
      $display("random burst %0d: len=%0d expect res=%0d ovf=%0d", r, rl, er, eo);
      run_burst("random", rl, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b0, er, eo);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
